// File: rtl/fft_butterfly3.sv
// fft_butterfly3: last radix-2 stage of the 8-point FFT. Captures one frame of
// stage-2 results, applies the W8^k twiddles in Q8, forms the final sum and
// difference pairs, and streams X0..X7 out over a valid/ready handshake.
module fft_butterfly3 #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 10,
  parameter int TW_Q8  = 181
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] fft_d1_real,
  input  logic signed [DATA_W-1:0] fft_d1_imag,
  input  logic signed [DATA_W-1:0] fft_d2_real,
  input  logic signed [DATA_W-1:0] fft_d2_imag,
  input  logic signed [DATA_W-1:0] fft_d3_real,
  input  logic signed [DATA_W-1:0] fft_d3_imag,
  input  logic signed [DATA_W-1:0] fft_d4_real,
  input  logic signed [DATA_W-1:0] fft_d4_imag,
  input  logic signed [DATA_W-1:0] fft_d5_real,
  input  logic signed [DATA_W-1:0] fft_d5_imag,
  input  logic signed [DATA_W-1:0] fft_d6_real,
  input  logic signed [DATA_W-1:0] fft_d6_imag,
  input  logic signed [DATA_W-1:0] fft_d7_real,
  input  logic signed [DATA_W-1:0] fft_d7_imag,
  input  logic signed [DATA_W-1:0] fft_d8_real,
  input  logic signed [DATA_W-1:0] fft_d8_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_idx,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     in_busy,
  output logic                     frame_done,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int PW = DATA_W + 2 + COEF_W;
  localparam logic signed [COEF_W-1:0] TW_C = COEF_W'(TW_Q8);

  typedef enum logic [1:0] {IDLE, CALC, DRAIN} state_t;

  state_t     state, state_nxt;
  logic       iv_q;
  logic       start;
  logic       accept;
  logic [2:0] ptr, ptr_nxt;

  logic signed [DATA_W-1:0] d_re [8];
  logic signed [DATA_W-1:0] d_im [8];
  logic signed [DATA_W-1:0] t_re_c [4];
  logic signed [DATA_W-1:0] t_im_c [4];
  logic signed [DATA_W-1:0] e_re_p0 [4];
  logic signed [DATA_W-1:0] e_im_p0 [4];
  logic signed [DATA_W-1:0] t_re_p0 [4];
  logic signed [DATA_W-1:0] t_im_p0 [4];
  logic signed [DATA_W-1:0] res_re_p1 [8];
  logic signed [DATA_W-1:0] res_im_p1 [8];

  // Sum and difference carry two guard bits so the later negation cannot overflow.
  function automatic logic signed [DATA_W+1:0] wide_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return (DATA_W+2)'(a) + (DATA_W+2)'(b);
  endfunction

  function automatic logic signed [DATA_W+1:0] wide_sub(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return (DATA_W+2)'(a) - (DATA_W+2)'(b);
  endfunction

  // Full-width Q8 multiply, floor shift by 8, then wrap back to the data width.
  function automatic logic signed [DATA_W-1:0] tw_scale(input logic signed [DATA_W+1:0] v);
    logic signed [PW-1:0] prod;
    prod = PW'(v) * PW'(TW_C);
    return DATA_W'(prod >>> 8);
  endfunction

  assign start  = in_valid & ~iv_q;
  assign accept = (state == DRAIN) & out_ready;

  // Gather the flat input ports into indexable arrays (index n holds d(n+1)).
  always_comb begin
    d_re[0] = fft_d1_real; d_im[0] = fft_d1_imag;
    d_re[1] = fft_d2_real; d_im[1] = fft_d2_imag;
    d_re[2] = fft_d3_real; d_im[2] = fft_d3_imag;
    d_re[3] = fft_d4_real; d_im[3] = fft_d4_imag;
    d_re[4] = fft_d5_real; d_im[4] = fft_d5_imag;
    d_re[5] = fft_d6_real; d_im[5] = fft_d6_imag;
    d_re[6] = fft_d7_real; d_im[6] = fft_d7_imag;
    d_re[7] = fft_d8_real; d_im[7] = fft_d8_imag;
  end

  // Twiddle products for W8^0..W8^3 on the odd half of the frame.
  always_comb begin
    t_re_c[0] = d_re[4];
    t_im_c[0] = d_im[4];
    t_re_c[1] = tw_scale(wide_add(d_re[5], d_im[5]));
    t_im_c[1] = tw_scale(wide_sub(d_im[5], d_re[5]));
    t_re_c[2] = d_im[6];
    t_im_c[2] = -d_re[6];
    t_re_c[3] = tw_scale(wide_sub(d_im[7], d_re[7]));
    t_im_c[3] = tw_scale(-wide_add(d_re[7], d_im[7]));
  end

  // Control registers: state, read pointer, edge detector, status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      iv_q       <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      iv_q       <= in_valid;
      frame_done <= accept && (ptr == 3'd7);
      if (start && (state != IDLE))
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // Next-state logic: a start is honoured only from IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        ptr_nxt   = 3'd0;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          ptr_nxt = ptr + 3'd1;
          if (ptr == 3'd7) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture even terms and twiddled odd terms at frame start.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      for (int k = 0; k < 4; k++) begin
        e_re_p0[k] <= d_re[k];
        e_im_p0[k] <= d_im[k];
        t_re_p0[k] <= t_re_c[k];
        t_im_p0[k] <= t_im_c[k];
      end
    end
  end

  // Stage p1: final butterflies into the natural-order result buffer.
  always_ff @(posedge clk) begin
    if (state == CALC) begin
      for (int k = 0; k < 4; k++) begin
        res_re_p1[k]   <= e_re_p0[k] + t_re_p0[k];
        res_im_p1[k]   <= e_im_p0[k] + t_im_p0[k];
        res_re_p1[k+4] <= e_re_p0[k] - t_re_p0[k];
        res_im_p1[k+4] <= e_im_p0[k] - t_im_p0[k];
      end
    end
  end

  // Output view is gated by state so reset clears it without a clock edge.
  always_comb begin
    out_valid = (state == DRAIN);
    in_busy   = (state != IDLE);
    out_idx   = out_valid ? ptr : 3'd0;
    out_real  = out_valid ? res_re_p1[ptr] : '0;
    out_imag  = out_valid ? res_im_p1[ptr] : '0;
  end

endmodule

// File: tb/tb_fft_butterfly3.sv
// tb_fft_butterfly3: directed-vector bench for fft_butterfly3.
module tb_fft_butterfly3;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                in_valid;
  logic                out_ready;
  logic                ovf_clr;
  logic signed [W-1:0] dr [8];
  logic signed [W-1:0] di [8];
  logic                out_valid;
  logic [2:0]          out_idx;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic                in_busy;
  logic                frame_done;
  logic                ovf;

  int errors = 0;
  int checks = 0;

  logic signed [W-1:0] cap_re [8];
  logic signed [W-1:0] cap_im [8];
  int lat;
  int ndone;
  int idx_err;

  fft_butterfly3 #(.DATA_W(W), .COEF_W(10), .TW_Q8(181)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .fft_d1_real(dr[0]), .fft_d1_imag(di[0]),
    .fft_d2_real(dr[1]), .fft_d2_imag(di[1]),
    .fft_d3_real(dr[2]), .fft_d3_imag(di[2]),
    .fft_d4_real(dr[3]), .fft_d4_imag(di[3]),
    .fft_d5_real(dr[4]), .fft_d5_imag(di[4]),
    .fft_d6_real(dr[5]), .fft_d6_imag(di[5]),
    .fft_d7_real(dr[6]), .fft_d7_imag(di[6]),
    .fft_d8_real(dr[7]), .fft_d8_imag(di[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_real(out_real), .out_imag(out_imag), .in_busy(in_busy),
    .frame_done(frame_done), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    for (int i = 0; i < 8; i++) begin
      dr[i] = '0;
      di[i] = '0;
    end
  endtask

  task automatic set_mixed();
    dr[0] = 10;  di[0] = 20;
    dr[1] = 3;   di[1] = -4;
    dr[2] = -7;  di[2] = 5;
    dr[3] = 1;   di[3] = 1;
    dr[4] = 2;   di[4] = 3;
    dr[5] = 100; di[5] = 50;
    dr[6] = -30; di[6] = 40;
    dr[7] = -60; di[7] = -20;
  endtask

  // Starts a frame with a one-cycle in_valid pulse and captures X0..X7 with
  // out_ready held high. With b2b set, in_valid rises together with ovf_clr
  // so that it is sampled on the edge that returns the FSM to IDLE.
  task automatic run_frame(input bit b2b);
    lat = -1; ndone = 0; idx_err = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (frame_done) ndone++;
    for (int c = 2; c <= 12; c++) begin
      if (lat < 0) begin
        tick();
        if (frame_done) ndone++;
        if (out_valid) lat = c;
      end
    end
    if (lat >= 0) begin
      for (int k = 0; k < 8; k++) begin
        if (out_idx != 3'(k)) idx_err++;
        cap_re[k] = out_real;
        cap_im[k] = out_imag;
        if (k == 7 && b2b) begin
          in_valid = 1'b1;
          ovf_clr  = 1'b1;
        end
        tick();
        if (frame_done) ndone++;
      end
      ovf_clr = 1'b0;
      tick();
      if (frame_done) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    clear_d();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_real !== 16'sd0 || out_imag !== 16'sd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b idx=%0d re=%0d im=%0d want 0 0 0 0",
               out_valid, out_idx, out_real, out_imag);
    end
    checks++;
    if (in_busy !== 1'b0 || frame_done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b ovf=%b want 0 0 0", in_busy, frame_done, ovf);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    er = '{256, 0, 0, 0, 256, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    clear_d();
    dr[0] = 256;
    run_frame(1'b0);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL impulse_latency: got %0d cycles want 2", lat);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL impulse_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL impulse_frame_done: got %0d pulses want 1", ndone);
    end
    checks++;
    if (idx_err !== 0) begin
      errors++;
      $display("FAIL impulse_idx_order: got %0d out-of-order indices want 0", idx_err);
    end
  endtask

  task automatic test_w1();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    er = '{0, 181, 0, 0, 0, -181, 0, 0};
    ei = '{0, -181, 0, 0, 0, 181, 0, 0};
    clear_d();
    dr[5] = 256;
    run_frame(1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL w1_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_w23();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    er = '{0, 0, 100, -181, 0, 0, -100, 181};
    ei = '{0, 0, 0, -181, 0, 0, 0, 181};
    clear_d();
    di[6] = 100;
    dr[7] = 256;
    run_frame(1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL w23_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_truncation();
    clear_d();
    dr[5] = 1;
    run_frame(1'b0);
    checks++;
    if (cap_re[1] !== 16'sd0 || cap_im[1] !== -16'sd1) begin
      errors++;
      $display("FAIL trunc_X1: got (%0d,%0d) want (0,-1)", cap_re[1], cap_im[1]);
    end
    checks++;
    if (cap_re[5] !== 16'sd0 || cap_im[5] !== 16'sd1) begin
      errors++;
      $display("FAIL trunc_X5: got (%0d,%0d) want (0,1)", cap_re[5], cap_im[5]);
    end
  endtask

  task automatic test_mixed();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    er = '{12, 109, 33, 29, 8, -103, -47, -27};
    ei = '{23, -40, 35, 57, 17, 32, -25, -55};
    set_mixed();
    run_frame(1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL mixed_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_backpressure_ovf();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    bit extra;
    er = '{12, 109, 33, 29, 8, -103, -47, -27};
    ei = '{23, -40, 35, 57, 17, 32, -25, -55};
    set_mixed();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      cap_re[k] = out_real;
      cap_im[k] = out_imag;
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_real !== 16'sd29 || out_imag !== 16'sd57) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b idx=%0d (%0d,%0d) want v=1 idx=3 (29,57)",
                 c, out_valid, out_idx, out_real, out_imag);
      end
      tick();
      if (c == 0) in_valid = 1'b1;
      if (c == 1) begin
        dr[0] = 999; di[0] = -999; dr[5] = 7; di[7] = 321;
      end
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b want 1", ovf);
    end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      cap_re[k] = out_real;
      cap_im[k] = out_imag;
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL stall_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
    extra = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL held_valid_single_frame: got extra frame=%b want 0", extra);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", ovf);
    end
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr  = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    er = '{12, 109, 33, 29, 8, -103, -47, -27};
    ei = '{23, -40, 35, 57, 17, 32, -25, -55};
    clear_d();
    dr[0] = 256;
    run_frame(1'b1);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ovf_set_wins: got %b want 1", ovf);
    end
    checks++;
    if (out_valid !== 1'b0 || in_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_rejected: got v=%b busy=%b want 0 0", out_valid, in_busy);
    end
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr  = 1'b0;
    set_mixed();
    run_frame(1'b0);
    checks++;
    if (lat !== 2 || ndone !== 1) begin
      errors++;
      $display("FAIL b2b_next_frame: got lat=%0d done=%0d want 2 1", lat, ndone);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL b2b_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic signed [W-1:0] er [8];
    logic signed [W-1:0] ei [8];
    bit done_seen;
    er = '{12, 109, 33, 29, 8, -103, -47, -27};
    ei = '{23, -40, 35, 57, 17, 32, -25, -55};
    set_mixed();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4) begin
      errors++;
      $display("FAIL mid_drain_pos: got v=%b idx=%0d want 1 4", out_valid, out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_real !== 16'sd0 || out_imag !== 16'sd0 || in_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b idx=%0d (%0d,%0d) busy=%b want 0 0 (0,0) 0",
               out_valid, out_idx, out_real, out_imag, in_busy);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (frame_done) done_seen = 1'b1;
      if (c == 1) rst_n = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got frame_done=%b want 0", done_seen);
    end
    run_frame(1'b0);
    checks++;
    if (lat !== 2 || ndone !== 1 || idx_err !== 0) begin
      errors++;
      $display("FAIL post_reset_frame: got lat=%0d done=%0d idxerr=%0d want 2 1 0", lat, ndone, idx_err);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_re[k] !== er[k] || cap_im[k] !== ei[k]) begin
        errors++;
        $display("FAIL post_reset_X%0d: got (%0d,%0d) want (%0d,%0d)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_w1();
    test_w23();
    test_truncation();
    test_mixed();
    test_backpressure_ovf();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
